// File: rtl/sram_like_resp_pkg.sv
// Shared types for the SRAM-like instruction responder.
// State encoding and wait-counter width.
package sram_like_resp_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD1,
    RD2,
    CAP,
    RESP
  } state_t;

endpackage

// File: rtl/sram_like_inst_responder_if.sv
// Dual-fetch SRAM-like instruction port between the CPU fetch
// unit (master) and the memory-side responder (slave).
interface sram_like_inst_responder_if;

  logic        inst_req_1;
  logic        inst_req_2;
  logic [31:0] inst_addr_1;
  logic [31:0] inst_addr_2;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        second_data_ok;
  logic [31:0] inst_rdata_1;
  logic [31:0] inst_rdata_2;

  modport master (
    output inst_req_1,
    output inst_req_2,
    output inst_addr_1,
    output inst_addr_2,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  second_data_ok,
    input  inst_rdata_1,
    input  inst_rdata_2
  );

  modport slave (
    input  inst_req_1,
    input  inst_req_2,
    input  inst_addr_1,
    input  inst_addr_2,
    output inst_addr_ok,
    output inst_data_ok,
    output second_data_ok,
    output inst_rdata_1,
    output inst_rdata_2
  );

endinterface

// File: rtl/sram_like_inst_responder_resp_wait_counter.sv
// Loadable down-counter pacing the WAIT state.
// done flags the last wait cycle (count == 1).
module resp_wait_counter
  import sram_like_resp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/sram_like_inst_responder.sv
// Memory-side responder for the dual-fetch SRAM-like instruction port.
// SRAM_LIKE_RESP_SEQ_CHECK_EN: serve word 2 only when it follows word 1.
module sram_like_inst_responder
  import sram_like_resp_pkg::*;
#(
  parameter int MEM_AW  = 16,
  parameter int LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  sram_like_inst_responder_if.slave bus,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  state_t state;

  logic [MEM_AW-1:0] a1;
  logic [MEM_AW-1:0] a2;
  logic              r2;
  logic [31:0]       word1;
  logic [31:0]       word2;
  logic              data_ok;
  logic              second_ok;

  logic              hs;
  logic [MEM_AW-1:0] in_a1;
  logic [MEM_AW-1:0] in_a2;
  logic              in_r2;
  logic              cnt_done;
  logic              unused_bits;

  assign in_a1 = bus.inst_addr_1[MEM_AW+1:2];
  assign in_a2 = bus.inst_addr_2[MEM_AW+1:2];

  // Byte offset and high bits are don't-care: the memory wraps.
  assign unused_bits = ^{bus.inst_addr_1[31:MEM_AW+2],
                         bus.inst_addr_1[1:0],
                         bus.inst_addr_2[31:MEM_AW+2],
                         bus.inst_addr_2[1:0]};

`ifdef SRAM_LIKE_RESP_SEQ_CHECK_EN
  assign in_r2 = bus.inst_req_2 &&
                 (in_a2 == in_a1 + MEM_AW'(1));
`else
  assign in_r2 = bus.inst_req_2;
`endif

  assign hs = bus.inst_req_1 && (state == IDLE) && !rst;

  assign bus.inst_addr_ok   = hs;
  assign bus.inst_data_ok   = data_ok;
  assign bus.second_data_ok = second_ok;
  assign bus.inst_rdata_1   = word1;
  assign bus.inst_rdata_2   = word2;

  resp_wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (hs),
    .load_val (CNT_W'(LATENCY)),
    .dec      (state == WAIT),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a1        <= '0;
      a2        <= '0;
      r2        <= 1'b0;
      word1     <= '0;
      word2     <= '0;
      data_ok   <= 1'b0;
      second_ok <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      data_ok   <= 1'b0;
      second_ok <= 1'b0;
      mem_en    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hs) begin
            a1 <= in_a1;
            a2 <= in_a2;
            r2 <= in_r2;
            if (LATENCY > 0) begin
              state <= WAIT;
            end else begin
              state    <= RD1;
              mem_en   <= 1'b1;
              mem_addr <= in_a1;
            end
          end
        end
        WAIT: begin
          if (cnt_done) begin
            state    <= RD1;
            mem_en   <= 1'b1;
            mem_addr <= a1;
          end
        end
        RD1: begin
          if (r2) begin
            state    <= RD2;
            mem_en   <= 1'b1;
            mem_addr <= a2;
          end else begin
            state <= CAP;
          end
        end
        RD2: begin
          word1 <= mem_rdata;
          state <= CAP;
        end
        CAP: begin
          if (r2) begin
            word2 <= mem_rdata;
          end else begin
            word1 <= mem_rdata;
            word2 <= '0;
          end
          data_ok   <= 1'b1;
          second_ok <= r2;
          state     <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_inst_responder.sv
// Bench for sram_like_inst_responder: LATENCY=0 and LATENCY=2 instances
// share one request stream and are checked against a schedule model.
module tb_sram_like_inst_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_like_inst_responder_if bus0 ();
  sram_like_inst_responder_if bus2 ();

  assign bus2.inst_req_1  = bus0.inst_req_1;
  assign bus2.inst_req_2  = bus0.inst_req_2;
  assign bus2.inst_addr_1 = bus0.inst_addr_1;
  assign bus2.inst_addr_2 = bus0.inst_addr_2;

  logic        mem_en0, mem_en2;
  logic [15:0] mem_addr0, mem_addr2;
  logic [31:0] mem_rdata0 = '0;
  logic [31:0] mem_rdata2 = '0;

  sram_like_inst_responder #(.MEM_AW(16), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .mem_en(mem_en0), .mem_addr(mem_addr0), .mem_rdata(mem_rdata0)
  );

  sram_like_inst_responder #(.MEM_AW(16), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .mem_en(mem_en2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2)
  );

  // mem[w] = A000_0000 | w, one-cycle read
  always @(posedge clk) begin
    if (mem_en0) mem_rdata0 <= 32'hA000_0000 | {16'h0, mem_addr0};
    if (mem_en2) mem_rdata2 <= 32'hA000_0000 | {16'h0, mem_addr2};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  int          lat[2]      = '{0, 2};
  int          busy_end[2] = '{-1, -1};
  int          resp_c[2]   = '{-1, -1};
  int          rd1_c[2]    = '{-1, -1};
  int          rd2_c[2]    = '{-1, -1};
  logic [15:0] ea1[2], ea2[2];
  logic [31:0] er1[2], er2[2];
  logic        er2v[2];
  logic [31:0] last1[2] = '{32'h0, 32'h0};
  logic [31:0] last2[2] = '{32'h0, 32'h0};

  logic        aok[2], dok[2], sok[2], men[2];
  logic [15:0] madr[2];
  logic [31:0] rd1[2], rd2[2];
  int          s_cyc;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_check();
    int c;
    c = cyc;
    s_cyc = c;
    aok[0] = bus0.inst_addr_ok;   aok[1] = bus2.inst_addr_ok;
    dok[0] = bus0.inst_data_ok;   dok[1] = bus2.inst_data_ok;
    sok[0] = bus0.second_data_ok; sok[1] = bus2.second_data_ok;
    rd1[0] = bus0.inst_rdata_1;   rd1[1] = bus2.inst_rdata_1;
    rd2[0] = bus0.inst_rdata_2;   rd2[1] = bus2.inst_rdata_2;
    men[0] = mem_en0;             men[1] = mem_en2;
    madr[0] = mem_addr0;          madr[1] = mem_addr2;
    for (int d = 0; d < 2; d++) begin
      string       p;
      logic        e_aok, e_dok, e_men, r2;
      logic [15:0] a1, a2;
      p = $sformatf("lat%0d", lat[d]);
      if (rst) begin
        chk1({p, "_rst_addr_ok"}, aok[d], 1'b0);
        chk1({p, "_rst_data_ok"}, dok[d], 1'b0);
        chk1({p, "_rst_second"}, sok[d], 1'b0);
        chk1({p, "_rst_mem_en"}, men[d], 1'b0);
        chk32({p, "_rst_mem_addr"}, {16'h0, madr[d]}, 32'h0);
        chk32({p, "_rst_rdata_1"}, rd1[d], 32'h0);
        chk32({p, "_rst_rdata_2"}, rd2[d], 32'h0);
        busy_end[d] = c;
        resp_c[d] = -1;
        rd1_c[d] = -1;
        rd2_c[d] = -1;
        last1[d] = '0;
        last2[d] = '0;
      end else begin
        e_aok = bus0.inst_req_1 && (c > busy_end[d]);
        e_dok = (c == resp_c[d]);
        e_men = (c == rd1_c[d]) || (c == rd2_c[d]);
        chk1({p, "_addr_ok"}, aok[d], e_aok);
        chk1({p, "_data_ok"}, dok[d], e_dok);
        chk1({p, "_second_data_ok"}, sok[d], e_dok && er2v[d]);
        chk1({p, "_mem_en"}, men[d], e_men);
        if (e_men)
          chk32({p, "_mem_addr"}, {16'h0, madr[d]},
                {16'h0, (c == rd1_c[d]) ? ea1[d] : ea2[d]});
        if (e_dok) begin
          chk32({p, "_rdata_1"}, rd1[d], er1[d]);
          chk32({p, "_rdata_2"}, rd2[d], er2[d]);
          last1[d] = er1[d];
          last2[d] = er2[d];
        end else if (c > busy_end[d]) begin
          chk32({p, "_hold_rdata_1"}, rd1[d], last1[d]);
          chk32({p, "_hold_rdata_2"}, rd2[d], last2[d]);
        end
        if (e_aok) begin
          a1 = bus0.inst_addr_1[17:2];
          a2 = bus0.inst_addr_2[17:2];
          r2 = bus0.inst_req_2;
`ifdef SRAM_LIKE_RESP_SEQ_CHECK_EN
          r2 = r2 && (a2 == a1 + 16'd1);
`endif
          ea1[d] = a1;
          ea2[d] = a2;
          er2v[d] = r2;
          rd1_c[d] = c + lat[d] + 1;
          rd2_c[d] = r2 ? c + lat[d] + 2 : -1;
          resp_c[d] = c + lat[d] + 3 + (r2 ? 1 : 0);
          busy_end[d] = resp_c[d];
          er1[d] = 32'hA000_0000 | {16'h0, a1};
          er2[d] = r2 ? (32'hA000_0000 | {16'h0, a2}) : 32'h0;
        end
      end
    end
  endtask

  // Called at the drive point (posedge+1); returns at the next one.
  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus0.inst_req_1 = 1'b0;
    bus0.inst_req_2 = 1'b0;
    repeat (n) cycle();
  endtask

  typedef struct {
    logic [31:0] a1;
    logic [31:0] a2;
    logic        r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        es;
    int          elat;
  } vec_t;

  task automatic run_vec(input vec_t v, input string nm);
    int          t;
    int          gl[2];
    logic [31:0] g1[2], g2[2];
    logic        gs[2];
    logic        found;
    gl = '{-1, -1};
    g1 = '{32'h0, 32'h0};
    g2 = '{32'h0, 32'h0};
    gs = '{1'b0, 1'b0};
    bus0.inst_req_1 = 1'b1;
    bus0.inst_req_2 = v.r2;
    bus0.inst_addr_1 = v.a1;
    bus0.inst_addr_2 = v.a2;
    found = 1'b0;
    t = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      cycle();
      if (aok[0]) begin
        found = 1'b1;
        t = s_cyc;
      end
    end
    chk1({nm, "_accepted"}, found, 1'b1);
    bus0.inst_req_1 = 1'b0;
    bus0.inst_req_2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      for (int d = 0; d < 2; d++) begin
        if (dok[d] && gl[d] < 0) begin
          gl[d] = s_cyc - t;
          g1[d] = rd1[d];
          g2[d] = rd2[d];
          gs[d] = sok[d];
        end
      end
    end
    chk32({nm, "_lat0"}, 32'(gl[0]), 32'(v.elat));
    chk32({nm, "_lat2"}, 32'(gl[1]), 32'(v.elat + 2));
    chk32({nm, "_rdata_1"}, g1[0], v.e1);
    chk32({nm, "_rdata_2"}, g2[0], v.e2);
    chk1({nm, "_second"}, gs[0], v.es);
    chk32({nm, "_lat2_rdata_1"}, g1[1], v.e1);
    chk32({nm, "_lat2_rdata_2"}, g2[1], v.e2);
  endtask

  vec_t tbl[6];

  initial begin
    int  t, tb;
    int  cnt;
    logic found;

    tbl[0] = '{32'h10, 32'h0, 1'b0, 32'hA000_0004, 32'h0, 1'b0, 3};
    tbl[1] = '{32'h20, 32'h24, 1'b1, 32'hA000_0008, 32'hA000_0009, 1'b1, 4};
    tbl[2] = '{32'h0, 32'h0, 1'b0, 32'hA000_0000, 32'h0, 1'b0, 3};
`ifdef SRAM_LIKE_RESP_SEQ_CHECK_EN
    tbl[3] = '{32'h20, 32'h40, 1'b1, 32'hA000_0008, 32'h0, 1'b0, 3};
`else
    tbl[3] = '{32'h20, 32'h40, 1'b1, 32'hA000_0008, 32'hA000_0010, 1'b1, 4};
`endif
    tbl[4] = '{32'hFFFF_FFFC, 32'h1, 1'b1, 32'hA000_FFFF, 32'hA000_0000, 1'b1, 4};
    tbl[5] = '{32'h103, 32'h106, 1'b1, 32'hA000_0040, 32'hA000_0041, 1'b1, 4};

    rst = 1'b1;
    bus0.inst_req_1 = 1'b0;
    bus0.inst_req_2 = 1'b0;
    bus0.inst_addr_1 = '0;
    bus0.inst_addr_2 = '0;
    repeat (3) cycle();
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      idle(8);
    end

    // Request B held while single-word A is in flight
    bus0.inst_req_1 = 1'b1;
    bus0.inst_req_2 = 1'b0;
    bus0.inst_addr_1 = 32'h10;
    found = 1'b0;
    t = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      cycle();
      if (aok[0]) begin found = 1'b1; t = s_cyc; end
    end
    chk1("held_a_accepted", found, 1'b1);
    bus0.inst_addr_1 = 32'h30;
    found = 1'b0;
    tb = t;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (aok[0]) begin found = 1'b1; tb = s_cyc; end
    end
    chk32("held_b_accept_offset", 32'(tb - t), 32'd4);
    bus0.inst_req_1 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (dok[0]) begin
        found = 1'b1;
        chk32("held_b_resp_offset", 32'(s_cyc - t), 32'd7);
        chk32("held_b_rdata_1", rd1[0], 32'hA000_000C);
      end
    end
    chk1("held_b_responded", found, 1'b1);
    idle(8);

    // Asynchronous reset while the LATENCY=0 instance sits in RD2
    bus0.inst_req_1 = 1'b1;
    bus0.inst_req_2 = 1'b1;
    bus0.inst_addr_1 = 32'h20;
    bus0.inst_addr_2 = 32'h24;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      cycle();
      if (aok[0]) found = 1'b1;
    end
    chk1("rst_txn_accepted", found, 1'b1);
    bus0.inst_req_1 = 1'b0;
    bus0.inst_req_2 = 1'b0;
    cycle();
    chk1("rd2_mem_en_before_rst", mem_en0, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk1("async_rst_data_ok", bus0.inst_data_ok, 1'b0);
    chk1("async_rst_mem_en", mem_en0, 1'b0);
    chk32("async_rst_mem_addr", {16'h0, mem_addr0}, 32'h0);
    chk32("async_rst_rdata_1", bus0.inst_rdata_1, 32'h0);
    chk32("async_rst_rdata_2", bus0.inst_rdata_2, 32'h0);
    cycle();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (dok[0] || dok[1]) cnt++;
    end
    chk32("no_data_ok_after_rst", 32'(cnt), 32'd0);
    run_vec(tbl[1], "post_rst");
    idle(8);

    // Random traffic against the schedule model
    for (int i = 0; i < 600; i++) begin
      bus0.inst_req_1 = ($urandom() % 3) != 0;
      bus0.inst_req_2 = ($urandom() % 2) == 0;
      bus0.inst_addr_1 = $urandom();
      bus0.inst_addr_2 = (($urandom() % 2) == 0) ?
                         bus0.inst_addr_1 + 32'd4 : $urandom();
      cycle();
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_like_inst_responder.md
Name: sram_like_inst_responder

Overview:
- Memory-side responder for the dual-fetch SRAM-like instruction interface.
- Accepts one request, carrying one or two word addresses, per transaction, and drives inst_addr_ok, inst_data_ok and second_data_ok.
- Reads the requested words from a single-port synchronous-read instruction memory, one word per cycle, and returns both words together in a single data_ok pulse.
- Sits between the CPU fetch port and the instruction RAM in the SoC and in simulation benches.

Parameters:
- MEM_AW, 16, word-address width of the backing memory (covers 4*2^MEM_AW bytes).
- LATENCY, 0, extra wait cycles inserted between address handshake and first memory access (0..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_req_1  in  1  request, first word.
- inst_req_2  in  1  second word also requested; sampled only at the inst_req_1 handshake.
- inst_addr_1  in  32  byte address, first word.
- inst_addr_2  in  32  byte address, second word.
- inst_addr_ok  out  1  request accepted this cycle.
- inst_data_ok  out  1  one-cycle pulse: inst_rdata_1 is valid.
- second_data_ok  out  1  high together with inst_data_ok when inst_rdata_2 is valid.
- inst_rdata_1  out  32  first word.
- inst_rdata_2  out  32  second word; 0 when not served.
- mem_en  out  1  memory read enable.
- mem_addr  out  MEM_AW  memory word address.
- mem_rdata  in  32  memory data, valid the cycle after mem_en.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE immediately.
  - All outputs are 0: addr_ok, data_ok, second_data_ok, rdata_1, rdata_2, mem_en, mem_addr.
  - Latched request fields and the wait counter are cleared.
- Reset mid-transaction aborts it: no data_ok is produced for the aborted request.
- Single outstanding transaction only.
- inst_addr_ok = inst_req_1 && state==IDLE (combinational). Handshake occurs when both are high.
- At the handshake the block latches:
  - a1 = inst_addr_1[MEM_AW+1:2]
  - a2 = inst_addr_2[MEM_AW+1:2]
  - r2 = inst_req_2
- Address handling:
  - Bits [1:0] and bits above MEM_AW+1 are ignored, so addresses wrap.
  - inst_req_2 without inst_req_1 is ignored.
- States:
  - IDLE: on handshake go to WAIT (counter=LATENCY) if LATENCY>0, else go to RD1.
  - WAIT: decrement counter; when counter==1, go to RD1.
  - RD1: mem_en=1, mem_addr=a1. Go to RD2 if r2, else CAP.
  - RD2: mem_en=1, mem_addr=a2; capture mem_rdata into word-1 register. Go to CAP.
  - CAP: capture mem_rdata into the word-2 register if r2, else into the word-1 register. Go to RESP.
  - RESP: inst_data_ok=1, second_data_ok=r2, rdata outputs from registers. Go to IDLE.
- Latency, handshake cycle T to the RESP cycle:
  - single-word request: T+3+LATENCY.
  - dual-word request: T+4+LATENCY.
- inst_rdata_1 and inst_rdata_2 hold their values after RESP until the next capture.
  - inst_rdata_2 is cleared to 0 in CAP of any single-word transaction.
- Back-to-back requests: the next handshake is possible at the earliest in the cycle after RESP (IDLE). A req held high during a transaction sees addr_ok=0 until then.
- mem_en=0 in IDLE, WAIT, CAP and RESP; mem_addr holds its last value.

Optional Feature:
- Macro SRAM_LIKE_RESP_SEQ_CHECK_EN.
- Defined: at the handshake, r2 is latched as inst_req_2 && (inst_addr_2[MEM_AW+1:2] == a1+1, mod 2^MEM_AW). A non-sequential second request is therefore served as single-word: second_data_ok=0, rdata_2=0, single-word latency.
- Undefined: a2 is served whatever its value.

Decomposition:
- Package sram_like_resp_pkg holds:
  - the state enum (IDLE, WAIT, RD1, RD2, CAP, RESP), 3 bits;
  - the latency-counter width constant (8).
- One sub-module, resp_wait_counter: loadable down-counter with load, dec and done (count==1) outputs, used for the WAIT state.

Test Plan:
Bench memory holds mem[w] = 32'hA000_0000 | w.
1. LATENCY=0; req1, addr1=0x10, req2=0.
   - addr_ok at T.
   - data_ok only at T+3: rdata_1=0xA0000004, second_data_ok=0, rdata_2=0.
2. LATENCY=0; dual request, addr1=0x20, addr2=0x24.
   - mem_en high at T+1 (addr 8) and T+2 (addr 9).
   - data_ok and second_data_ok at T+4: rdata_1=0xA0000008, rdata_2=0xA0000009.
3. LATENCY=2; single request, addr1=0x0.
   - data_ok at T+5 with rdata_1=0xA0000000.
   - No mem_en during T+1..T+2.
4. Request B held high from T+1 while request A (single) is in progress.
   - addr_ok stays 0 until T+4 (IDLE); B is accepted at T+4.
   - B's data_ok at T+7.
5. rst pulsed asynchronously during RD2.
   - All outputs go to 0 before the next clock edge; no data_ok follows.
   - A new request after reset completes normally with correct data.
6. addr1=0x20, addr2=0x40.
   - With SRAM_LIKE_RESP_SEQ_CHECK_EN: data_ok at T+3, second_data_ok=0, rdata_2=0.
   - Without it: data_ok at T+4, second_data_ok=1, rdata_2=0xA0000010.
